// File: rtl/sobel_row_serializer.sv
// Drains full filtered rows from a two-entry ping-pong row buffer into a
// {R,G,B} pixel stream with line/frame position flags and backpressure.
//
// state   | meaning
// S_EMPTY | no row buffered, pixel output idle
// S_ONE   | one row buffered, draining buf[rp]
// S_FULL  | both rows buffered, upstream held off
module sobel_row_serializer #(
   parameter int COLS  = 256,
   parameter int ROWS  = 256,
   parameter int WIDTH = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [COLS*WIDTH*3-1:0] row_in,
   input  logic                    row_valid,
   output logic                    row_ready,
   output logic [3*WIDTH-1:0]      pix_data,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic                    pix_sol,
   output logic                    pix_eol,
   output logic                    pix_sof,
   output logic                    pix_eof,
   output logic                    frame_done
);

   localparam int PW = 3 * WIDTH;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            wp_q, rp_q;
   logic [CW-1:0]   col_q;
   logic [RW-1:0]   row_q;
   logic            frame_done_q;
   logic [PW-1:0]   mem_q [2][COLS];

   logic            accept, xfer, last_col, last_row, release_row;

   assign accept      = row_valid && row_ready;
   assign xfer        = pix_valid && pix_ready;
   assign last_col    = (col_q == CW'(COLS - 1));
   assign last_row    = (row_q == RW'(ROWS - 1));
   assign release_row = xfer && last_col;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= S_EMPTY;
      else     state_q <= state_d;
   end

   // A same-cycle accept and release leaves occupancy unchanged.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (accept) state_d = S_ONE;
         S_ONE: begin
            if (accept && !release_row)      state_d = S_FULL;
            else if (!accept && release_row) state_d = S_EMPTY;
         end
         S_FULL:  if (release_row) state_d = S_ONE;
         default: state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      row_ready  = (state_q != S_FULL) && !RST;
      pix_valid  = (state_q != S_EMPTY);
      pix_data   = pix_valid ? mem_q[rp_q][col_q] : '0;
      pix_sol    = pix_valid && (col_q == '0);
      pix_eol    = pix_valid && last_col;
      pix_sof    = pix_valid && (col_q == '0) && (row_q == '0);
      pix_eof    = pix_valid && last_col && last_row;
      frame_done = frame_done_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wp_q         <= 1'b0;
         rp_q         <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= release_row && last_row;
         if (accept) wp_q <= ~wp_q;
         if (xfer) begin
            if (last_col) begin
               col_q <= '0;
               rp_q  <= ~rp_q;
               row_q <= last_row ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   // Row storage needs no reset; output is masked while nothing is buffered.
   always_ff @(posedge CLK) begin
      if (accept) begin
         for (int c = 0; c < COLS; c++)
            mem_q[wp_q][c] <= row_in[(COLS-c)*PW-1 -: PW];
      end
   end

endmodule

// File: tb/tb_sobel_row_serializer.sv
// Bench for sobel_row_serializer: a full-size instance for the 256-pixel row
// pattern and a 4x3 instance checked every cycle against a queue-based model.
module tb_sobel_row_serializer;

   localparam int SC = 4;
   localparam int SR = 3;
   localparam int BC = 256;
   localparam int PW = 24;

   logic clk = 0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // small instance
   logic              rst = 1;
   logic [SC*PW-1:0]  s_row_in = '0;
   logic              s_row_valid = 0, s_row_ready;
   logic [PW-1:0]     s_pix_data;
   logic              s_pix_valid, s_pix_ready = 0;
   logic              s_sol, s_eol, s_sof, s_eof, s_fd;

   sobel_row_serializer #(.COLS(SC), .ROWS(SR), .WIDTH(8)) dut_s (
      .CLK(clk), .RST(rst), .row_in(s_row_in), .row_valid(s_row_valid),
      .row_ready(s_row_ready), .pix_data(s_pix_data), .pix_valid(s_pix_valid),
      .pix_ready(s_pix_ready), .pix_sol(s_sol), .pix_eol(s_eol),
      .pix_sof(s_sof), .pix_eof(s_eof), .frame_done(s_fd));

   // full-size instance
   logic              b_rst = 1;
   logic [BC*PW-1:0]  b_row_in = '0;
   logic              b_row_valid = 0, b_row_ready;
   logic [PW-1:0]     b_pix_data;
   logic              b_pix_valid, b_pix_ready = 0;
   logic              b_sol, b_eol, b_sof, b_eof, b_fd;

   sobel_row_serializer dut_b (
      .CLK(clk), .RST(b_rst), .row_in(b_row_in), .row_valid(b_row_valid),
      .row_ready(b_row_ready), .pix_data(b_pix_data), .pix_valid(b_pix_valid),
      .pix_ready(b_pix_ready), .pix_sol(b_sol), .pix_eol(b_eol),
      .pix_sof(b_sof), .pix_eof(b_eof), .frame_done(b_fd));

   // Model: queue of pixels still owed downstream, plus a running pixel index.
   logic [PW-1:0] q[$];
   int  idx = 0;
   bit  exp_fd = 0;
   bit  m_accept = 0;
   int  m_held;
   bit  m_acc, m_xf;

   function automatic int rows_held();
      return (q.size() + SC - 1) / SC;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         idx      = 0;
         exp_fd   = 0;
         m_accept = 0;
      end else begin
         m_held = rows_held();
         m_acc  = s_row_valid && (m_held != 2);
         m_xf   = (q.size() != 0) && s_pix_ready;
         exp_fd = 0;
         if (m_xf) begin
            void'(q.pop_front());
            if (idx % (SC*SR) == SC*SR - 1) exp_fd = 1;
            idx++;
         end
         if (m_acc)
            for (int c = 0; c < SC; c++) q.push_back(s_row_in[(SC-c)*PW-1 -: PW]);
         m_accept = m_acc;
      end
   end

   always @(negedge clk) begin
      int col, row;
      chk("s_row_ready", s_row_ready, !rst && rows_held() != 2);
      chk("s_pix_valid", s_pix_valid, q.size() != 0);
      chk("s_frame_done", s_fd, !rst && exp_fd);
      if (!rst && q.size() != 0) begin
         col = idx % SC;
         row = (idx / SC) % SR;
         chk("s_pix_data", s_pix_data, q[0]);
         chk("s_sol", s_sol, col == 0);
         chk("s_eol", s_eol, col == SC-1);
         chk("s_sof", s_sof, col == 0 && row == 0);
         chk("s_eof", s_eof, col == SC-1 && row == SR-1);
      end
   end

   task automatic drive_cycles(int n, int pv, int pr);
      repeat (n) begin
         @(posedge clk); #2;
         if (m_accept || !s_row_valid) begin
            for (int c = 0; c < SC; c++) s_row_in[(SC-c)*PW-1 -: PW] = PW'($urandom);
            s_row_valid = ($urandom_range(99) < pv);
         end
         s_pix_ready = ($urandom_range(99) < pr);
      end
   endtask

   task automatic drain();
      @(posedge clk); #2;
      s_row_valid = 0;
      s_pix_ready = 1;
      repeat (3*SC + 2) @(posedge clk);
   endtask

   // Directed row {c,c,c} into an empty small instance, with literal checks.
   task automatic directed_row();
      logic [7:0] b;
      @(posedge clk); #2;
      for (int c = 0; c < SC; c++) begin
         b = 8'(c);
         s_row_in[(SC-c)*PW-1 -: PW] = {b, b, b};
      end
      s_row_valid = 1;
      s_pix_ready = 1;
      @(posedge clk); #2;
      s_row_valid = 0;
      @(negedge clk);
      chk("lit_valid0", s_pix_valid, 1);
      chk("lit_pix0", s_pix_data, 24'h000000);
      chk("lit_sof0", s_sof, 1);
      chk("lit_sol0", s_sol, 1);
      @(negedge clk);
      chk("lit_pix1", s_pix_data, 24'h010101);
      chk("lit_sol1", s_sol, 0);
      @(negedge clk);
      chk("lit_pix2", s_pix_data, 24'h020202);
      @(negedge clk);
      chk("lit_pix3", s_pix_data, 24'h030303);
      chk("lit_eol3", s_eol, 1);
      @(negedge clk);
      chk("lit_empty", s_pix_valid, 0);
   endtask

   initial begin
      logic [7:0] b;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_b_row_ready", b_row_ready, 0);
      chk("rst_b_pix_valid", b_pix_valid, 0);
      chk("rst_b_pix_data", b_pix_data, 0);
      chk("rst_b_fd", b_fd, 0);
      chk("rst_s_pix_data", s_pix_data, 0);
      @(posedge clk); #2;
      rst   = 0;
      b_rst = 0;

      // 256-pixel row on the full-size instance
      @(posedge clk); #2;
      for (int c = 0; c < BC; c++) begin
         b = 8'(c);
         b_row_in[(BC-c)*PW-1 -: PW] = {b, b, b};
      end
      b_row_valid = 1;
      b_pix_ready = 1;
      @(negedge clk);
      chk("b_ready_after_rst", b_row_ready, 1);
      chk("b_valid_pre", b_pix_valid, 0);
      @(posedge clk); #2;
      b_row_valid = 0;
      for (int c = 0; c < BC; c++) begin
         @(negedge clk);
         b = 8'(c);
         chk("b_valid", b_pix_valid, 1);
         chk("b_pix", b_pix_data, {b, b, b});
         chk("b_sol", b_sol, c == 0);
         chk("b_eol", b_eol, c == BC-1);
         chk("b_sof", b_sof, c == 0);
         chk("b_eof", b_eof, 0);
      end
      @(negedge clk);
      chk("b_drained", b_pix_valid, 0);
      chk("b_ready_end", b_row_ready, 1);

      // small instance: directed, then randomized phases
      directed_row();
      drive_cycles(60, 100, 100);
      drive_cycles(200, 70, 50);
      drive_cycles(100, 30, 90);
      drive_cycles(80, 100, 100);

      // asynchronous reset mid-stream
      @(posedge clk); #6;
      rst = 1;
      #1;
      chk("midrst_valid", s_pix_valid, 0);
      chk("midrst_ready", s_row_ready, 0);
      @(posedge clk); #2;
      s_row_valid = 0;
      rst = 0;
      directed_row();

      drive_cycles(150, 80, 60);
      drain();
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sobel_row_serializer.md
# sobel_row_serializer

Row-to-pixel serializer that drains the wide row outputs of the Sobel row filter into a 24-bit RGB pixel stream for the downstream writer or display path. It accepts full 256-pixel rows through a valid/ready handshake, holds up to two rows in a ping-pong buffer, and emits pixels one per cycle under downstream backpressure. It tracks column and row position and flags line and frame boundaries.

## Interface
- COLS, 256, pixels per row
- ROWS, 256, rows per frame
- WIDTH, 8, bits per colour channel; a pixel is 3*WIDTH bits, R:G:B from MSB
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- row_in  in  COLS*WIDTH*3  one filtered row; pixel 0 occupies the top 3*WIDTH bits, pixel c occupies row_in[(COLS-c)*3*WIDTH-1 -: 3*WIDTH]
- row_valid  in  1  row_in holds a valid row
- row_ready  out  1  serializer can accept a row this cycle
- pix_data  out  3*WIDTH  current pixel, {R,G,B}
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts pixel
- pix_sol  out  1  current pixel is column 0
- pix_eol  out  1  current pixel is column COLS-1
- pix_sof  out  1  current pixel is row 0, column 0
- pix_eof  out  1  current pixel is row ROWS-1, column COLS-1
- frame_done  out  1  one-cycle pulse after the eof pixel transfers

## Operation
- Storage: two row registers buf0/buf1, write pointer wp, read pointer rp, occupancy cnt (0..2).
- States by cnt: EMPTY (0), ONE (1), FULL (2).
- row_ready = (cnt != 2) and not RST. Row accept = row_valid & row_ready: row_in captured into buf[wp], wp toggles.
- pix_valid = (cnt != 0). pix_data = pixel col of buf[rp], purely from registered state.
- Pixel transfer = pix_valid & pix_ready: col increments. At col = COLS-1, col wraps to 0, rp toggles, the row is released (cnt decrements), and row increments.
- At row = ROWS-1 with the last column transferred, row wraps to 0 and frame_done pulses the next cycle.
- Same-cycle row accept and last-pixel release: cnt is unchanged, both pointers toggle.
- FULL: row_ready is 0 even if the final pixel drains that cycle. There is no bypass.
- pix_valid high with pix_ready low: pix_data and all flags hold stable. Pixels are never dropped or repeated.
- row_valid while row_ready is low is ignored. The upstream source holds the row.
- Flags are decoded from registered col/row and are meaningful only when pix_valid = 1.

## Timing
- Reset values: cnt=0, wp=rp=0, col=0, row=0, pix_valid=0, row_ready=0 during RST and 1 from the first cycle after release, frame_done=0, pix_data=0.
- Latency: row accepted at edge k makes pix_valid=1 with pixel 0 from cycle k+1.
- Throughput is 1 pixel/cycle with pix_ready held high. Back-to-back rows stream with no bubble when the next row is accepted before the current row's last pixel.
- RST mid-row or mid-frame: all buffered data is discarded, counters return to 0, and the next accepted row is treated as row 0 / sof.
- col and row widths are clog2(COLS) and clog2(ROWS). Wrap is by explicit compare to COLS-1 / ROWS-1, not natural overflow, so non-power-of-2 sizes work.

## Test plan
- Reset then single row with pixel c = {c,c,c} (8-bit), pix_ready=1 -> pix_valid rises 1 cycle after accept; 256 pixels 0x000000..0xFFFFFF in order; sol on first, eol on last, sof on first; cnt returns to 0.
- Three rows offered back-to-back, pix_ready=1 -> row_ready drops after the second accept and reasserts the cycle after row 0's last pixel transfers; 768 pixels with no gap.
- pix_ready toggled by random pattern (50%) over 2 rows -> pix_data stable while stalled; output sequence identical to the no-stall run.
- Full frame with COLS=4, ROWS=3 -> 12 pixels; pix_eof only on row 2 col 3; frame_done pulses once, one cycle later; the next row reports sof again.
- Same-cycle row accept at cnt=1 and last-pixel transfer -> cnt stays 1; the next pixel comes from the new row, column 0, with sol=1.
- RST asserted at pixel 100 of row 5 -> pix_valid=0 and row_ready=0 immediately; after release the first accepted row emits sof=1, col 0.
